loop_ctrl_fsm: RTL and testbench
================================

Name: loop_ctrl_fsm

Overview:
- Control sequencer directly upstream of the audio looper.
- Turns raw user buttons and a per-sample strobe from the codec into the looper's level controls: write (record), read (play) and reverse.
- Tracks recorded loop length, auto-stops recording at capacity, and guarantees write and read are never asserted together.
- Sits between the board I/O (KEY/SW) and the looper; audio data does not pass through it.

Parameters:
CNT_WIDTH, 16, width of the sample counter; matches the looper address width.
MAX_LEN, 65535, maximum recorded samples; recording auto-ends when reached; must be ≤ 2**CNT_WIDTH-1 and ≥1.

Ports:
clk  input  1  system clock (50 MHz).
reset  input  1  synchronous, active-low reset (0 = reset).
rec_btn  input  1  record button, raw asynchronous level, active-high.
play_btn  input  1  play/pause button, raw asynchronous level, active-high.
clr_btn  input  1  clear-loop button, raw asynchronous level, active-high.
rev_sw  input  1  reverse switch, raw asynchronous level.
sample_tick  input  1  one-cycle strobe per audio sample (codec read_ready & write_ready).
write  output  1  record enable to looper.
read  output  1  playback enable to looper.
reverse  output  1  reverse playback to looper.
loop_len  output  CNT_WIDTH  samples recorded in the current/last take.
full  output  1  high while loop_len == MAX_LEN.
state_o  output  2  current state encoding for LEDs (EMPTY=0, RECORD=1, PLAY=2, PAUSE=3).

Behaviour:
- Reset (reset==0 at a clk edge): state EMPTY; write=0, read=0, reverse=0, loop_len=0, full=0, state_o=0; all synchroniser and edge-detect flops cleared to 0.
- Input conditioning: each of rec_btn, play_btn, clr_btn and rev_sw passes through a 2-FF synchroniser.
- Press pulse = synchronised level & ~previous synchronised level, one cycle wide. A held button yields exactly one press.
- Latency: a button high first sampled at edge k gives a press pulse in the cycle after edge k+1. State and outputs change at edge k+2.
- Press priority when pulses coincide: clr > rec > play. Only the highest-priority press acts that cycle.
- State transitions:
  - Any state, clr press -> EMPTY, loop_len=0.
  - EMPTY, rec -> RECORD, loop_len=0. play is ignored.
  - RECORD, rec or play -> PLAY if loop_len>0, else EMPTY.
  - RECORD, sample_tick with loop_len==MAX_LEN-1 -> loop_len=MAX_LEN and PLAY in the same edge (auto-stop).
  - PLAY, play -> PAUSE; rec -> RECORD with loop_len=0 (new take overwrites).
  - PAUSE, play -> PLAY; rec -> RECORD with loop_len=0.
- Counter: increments by 1 on each sample_tick while in RECORD. It never exceeds MAX_LEN and holds its value in all other states.
  - If a press and a sample_tick coincide in RECORD, the tick is counted first; the exit decision uses the incremented value.
- Outputs are registered and decoded from the next-state value: write = (state==RECORD), read = (state==PLAY). Both are never 1 simultaneously in any cycle.
- reverse: takes the synchronised rev_sw value only on a sample_tick while in PLAY; otherwise it holds. It is forced to 0 on entry to RECORD or EMPTY. This keeps the direction change sample-aligned.
- full = (loop_len == MAX_LEN), registered alongside loop_len.
- Reset mid-RECORD or mid-PLAY: everything returns to reset values at that edge; presses pending in the pipeline are discarded.
- Tick-free operation: with sample_tick tied 0, transitions still occur on presses; loop_len stays 0, so RECORD -> rec press -> EMPTY.

Test Plan:
- Reset then rec press, 5 sample_ticks, rec press -> write=1 for the whole take; loop_len=5; then state PLAY (read=1, write=0); state_o=2.
- MAX_LEN=8: record with continuous ticks -> on the 8th tick loop_len=8, full=1, write drops and read rises at the same edge with no button press.
- In PLAY, press clr, rec and play in the same cycle -> EMPTY, loop_len=0, read=0, write=0.
- In PLAY, toggle rev_sw between ticks -> reverse changes only at the first sample_tick edge after synchronisation; in PAUSE it holds its value.
- Hold rec_btn high for 100 cycles from EMPTY -> exactly one transition to RECORD; state changes at the second edge after first sampling.
- Assert reset low during RECORD at loop_len=3 -> next edge: all outputs 0, state EMPTY; then a rec press starts a new take from 0. Property: never (write & read).

Source files
------------

// File: rtl/loop_ctrl_fsm.sv
// Looper control sequencer: conditions raw buttons into press pulses and drives
// the looper's write/read/reverse levels while tracking the recorded loop length.
module loop_ctrl_fsm #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_LEN   = 65535
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rec_btn,
    input  logic                 play_btn,
    input  logic                 clr_btn,
    input  logic                 rev_sw,
    input  logic                 sample_tick,
    output logic                 write,
    output logic                 read,
    output logic                 reverse,
    output logic [CNT_WIDTH-1:0] loop_len,
    output logic                 full,
    output logic [1:0]           state_o
);

    localparam logic [1:0] S_EMPTY  = 2'd0;
    localparam logic [1:0] S_RECORD = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_PAUSE  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] LEN_MAX = CNT_WIDTH'(MAX_LEN);

    // Bit order of the conditioned inputs: {rev, clr, play, rec}
    logic [3:0] sync_meta;
    logic [3:0] sync_q;
    logic [3:0] sync_prev;
    logic [3:0] press;

    logic rec_p;
    logic play_p;
    logic clr_p;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_WIDTH-1:0] len_nxt;
    logic [CNT_WIDTH-1:0] len_ticked;
    logic                 rev_nxt;

    assign press = sync_q & ~sync_prev;

    // Only the highest-priority press acts: clr > rec > play.
    assign clr_p  = press[2];
    assign rec_p  = press[0] & ~press[2];
    assign play_p = press[1] & ~press[2] & ~press[0];

    assign len_ticked = (sample_tick && loop_len != LEN_MAX)
                      ? loop_len + CNT_WIDTH'(1)
                      : loop_len;

    assign state_o = state;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        len_nxt   = loop_len;
        rev_nxt   = reverse;

        case (state)
            S_EMPTY: begin
                if (rec_p) begin
                    state_nxt = S_RECORD;
                    len_nxt   = '0;
                end
            end
            S_RECORD: begin
                // A coincident tick is counted before the exit decision.
                len_nxt = len_ticked;
                if (rec_p || play_p)
                    state_nxt = (len_ticked != '0) ? S_PLAY : S_EMPTY;
                else if (len_ticked == LEN_MAX)
                    state_nxt = S_PLAY;
            end
            S_PLAY: begin
                if (play_p) begin
                    state_nxt = S_PAUSE;
                end else if (rec_p) begin
                    state_nxt = S_RECORD;
                    len_nxt   = '0;
                end
            end
            default: begin
                if (play_p) begin
                    state_nxt = S_PLAY;
                end else if (rec_p) begin
                    state_nxt = S_RECORD;
                    len_nxt   = '0;
                end
            end
        endcase

        if (clr_p) begin
            state_nxt = S_EMPTY;
            len_nxt   = '0;
        end

        // Direction only changes on a sample boundary during playback.
        if (state_nxt == S_RECORD || state_nxt == S_EMPTY)
            rev_nxt = 1'b0;
        else if (state == S_PLAY && sample_tick)
            rev_nxt = sync_q[3];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_q    <= '0;
            sync_prev <= '0;
            state     <= S_EMPTY;
            loop_len  <= '0;
            full      <= 1'b0;
            write     <= 1'b0;
            read      <= 1'b0;
            reverse   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep the synchroniser a true shift register.
            sync_meta <= {rev_sw, clr_btn, play_btn, rec_btn};
            sync_q    <= sync_meta;
            sync_prev <= sync_q;
            state     <= state_nxt;
            loop_len  <= len_nxt;
            full      <= (len_nxt == LEN_MAX);
            write     <= (state_nxt == S_RECORD);
            read      <= (state_nxt == S_PLAY);
            reverse   <= rev_nxt;
        end
    end

endmodule

// File: tb/tb_loop_ctrl_fsm.sv
// Directed scoreboard bench for loop_ctrl_fsm, built with MAX_LEN=8 so the
// auto-stop boundary is reachable in a handful of ticks.
module tb_loop_ctrl_fsm;

    localparam int CW = 16;
    localparam int ML = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          rec_btn, play_btn, clr_btn, rev_sw, sample_tick;
    logic          write, read, reverse, full;
    logic [CW-1:0] loop_len;
    logic [1:0]    state_o;

    typedef struct {
        string      tag;
        logic       w;
        logic       r;
        logic       rv;
        int         len;
        logic       f;
        logic [1:0] st;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    loop_ctrl_fsm #(.CNT_WIDTH(CW), .MAX_LEN(ML)) dut (
        .clk         (clk),
        .reset       (reset),
        .rec_btn     (rec_btn),
        .play_btn    (play_btn),
        .clr_btn     (clr_btn),
        .rev_sw      (rev_sw),
        .sample_tick (sample_tick),
        .write       (write),
        .read        (read),
        .reverse     (reverse),
        .loop_len    (loop_len),
        .full        (full),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // write and read must never be high together.
    always @(negedge clk) begin
        n_assert++;
        assert (!(write === 1'b1 && read === 1'b1))
        else begin
            n_fail++;
            $error("FAIL excl: write=%b read=%b required not both 1", write, read);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish before 500us");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exv);
        n_assert++;
        assert (obs === exv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exv);
        end
    endtask

    task automatic expect_out(input string tag, input logic w, input logic r, input logic rv,
                              input int len, input logic f, input logic [1:0] st);
        exp_t e;
        e.tag = tag; e.w = w; e.r = r; e.rv = rv; e.len = len; e.f = f; e.st = st;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_assert++;
        assert (sb.size() > 0)
        else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp({e.tag, ".write"},   {31'd0, write},   {31'd0, e.w});
            cmp({e.tag, ".read"},    {31'd0, read},    {31'd0, e.r});
            cmp({e.tag, ".reverse"}, {31'd0, reverse}, {31'd0, e.rv});
            cmp({e.tag, ".len"},     {16'd0, loop_len}, e.len[31:0]);
            cmp({e.tag, ".full"},    {31'd0, full},    {31'd0, e.f});
            cmp({e.tag, ".state"},   {30'd0, state_o}, {30'd0, e.st});
        end
    endtask

    // Buttons go high; state changes at the third edge, where an optional tick coincides.
    task automatic press(input logic r, input logic p, input logic c, input logic tk);
        rec_btn = r; play_btn = p; clr_btn = c;
        @(negedge clk);
        @(negedge clk);
        sample_tick = tk;
        @(negedge clk);
        sample_tick = 1'b0;
        check_out();
        rec_btn = 1'b0; play_btn = 1'b0; clr_btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check_out();
    endtask

    task automatic wait_sync();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        rec_btn = 1'b0; play_btn = 1'b0; clr_btn = 1'b0; rev_sw = 1'b0; sample_tick = 1'b0;
        repeat (2) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0, 2'd0);
        check_out();
        reset = 1'b1;
        @(negedge clk);

        // Basic take of five samples.
        expect_out("rec_start", 1, 0, 0, 0, 0, 2'd1);
        press(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            expect_out($sformatf("take_tick%0d", i), 1, 0, 0, i, 0, 2'd1);
            tick();
        end
        expect_out("rec_stop", 0, 1, 0, 5, 0, 2'd2);
        press(1, 0, 0, 0);

        // Reverse only follows the switch on a tick while playing.
        rev_sw = 1'b1;
        wait_sync();
        expect_out("rev_no_tick", 0, 1, 0, 5, 0, 2'd2);
        check_out();
        expect_out("rev_on_tick", 0, 1, 1, 5, 0, 2'd2);
        tick();
        rev_sw = 1'b0;
        wait_sync();
        expect_out("rev_hold", 0, 1, 1, 5, 0, 2'd2);
        check_out();
        expect_out("pause", 0, 0, 1, 5, 0, 2'd3);
        press(0, 1, 0, 0);
        expect_out("pause_tick_hold", 0, 0, 1, 5, 0, 2'd3);
        tick();
        expect_out("resume", 0, 1, 1, 5, 0, 2'd2);
        press(0, 1, 0, 0);
        expect_out("rev_clear_tick", 0, 1, 0, 5, 0, 2'd2);
        tick();
        rev_sw = 1'b1;
        wait_sync();
        expect_out("rev_set_again", 0, 1, 1, 5, 0, 2'd2);
        tick();

        // clr wins over rec and play; reverse forced low.
        expect_out("clr_priority", 0, 0, 0, 0, 0, 2'd0);
        press(1, 1, 1, 0);
        rev_sw = 1'b0;
        wait_sync();

        // Held rec button yields one transition, two edges after first sampling.
        rec_btn = 1'b1;
        repeat (2) @(negedge clk);
        expect_out("hold_before", 0, 0, 0, 0, 0, 2'd0);
        check_out();
        @(negedge clk);
        expect_out("hold_enter", 1, 0, 0, 0, 0, 2'd1);
        check_out();
        repeat (97) @(negedge clk);
        expect_out("hold_stay", 1, 0, 0, 0, 0, 2'd1);
        check_out();
        rec_btn = 1'b0;
        wait_sync();

        // Tick-free: rec with loop_len 0 returns to EMPTY.
        expect_out("empty_take", 0, 0, 0, 0, 0, 2'd0);
        press(1, 0, 0, 0);

        // Auto-stop at capacity on continuous ticks.
        expect_out("auto_start", 1, 0, 0, 0, 0, 2'd1);
        press(1, 0, 0, 0);
        sample_tick = 1'b1;
        for (int i = 1; i <= ML; i++) begin
            @(negedge clk);
            if (i < ML) expect_out($sformatf("auto_tick%0d", i), 1, 0, 0, i, 0, 2'd1);
            else        expect_out("auto_stop", 0, 1, 0, ML, 1, 2'd2);
            check_out();
        end
        sample_tick = 1'b0;
        @(negedge clk);
        expect_out("full_hold", 0, 1, 0, ML, 1, 2'd2);
        check_out();

        // New take overwrites, then reset mid-record.
        expect_out("overwrite", 1, 0, 0, 0, 0, 2'd1);
        press(1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            expect_out($sformatf("pre_reset_tick%0d", i), 1, 0, 0, i, 0, 2'd1);
            tick();
        end
        reset = 1'b0;
        @(negedge clk);
        expect_out("mid_reset", 0, 0, 0, 0, 0, 2'd0);
        check_out();
        reset = 1'b1;
        @(negedge clk);

        // Press coinciding with a tick: tick counted first, so exit goes to PLAY.
        expect_out("post_reset_rec", 1, 0, 0, 0, 0, 2'd1);
        press(1, 0, 0, 0);
        expect_out("press_with_tick", 0, 1, 0, 1, 0, 2'd2);
        press(1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
